// File: rtl/btn_input_conditioner_pkg.sv
// Shared definitions for the front-panel push-button conditioner.
//   btn_state_e : per-channel hold-tracking FSM states
//   cnt_width() : width of the hold/repeat tick counter
package btn_input_conditioner_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHeld = 2'd1,
        StLong = 2'd2
    } btn_state_e;

    // The counter must reach the larger of the two thresholds without wrapping.
    function automatic int unsigned cnt_width(input int unsigned long_ticks,
                                              input int unsigned repeat_ticks);
        int unsigned max_ticks;
        max_ticks = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
        if (max_ticks == 0) begin
            return 1;
        end
        return $clog2(max_ticks + 1);
    endfunction

endpackage

// File: rtl/btn_input_conditioner_channel.sv
// One push-button channel: 2-FF synchroniser, tick-sampled stability filter with
// hysteresis, press/release edge pulses and long-press / auto-repeat FSM.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   tick           : one-cycle sample enable from the shared divider
//   btn            : raw asynchronous button input
//   level          : debounced level
//   press_pulse    : 1-clk pulse on debounced 0->1
//   release_pulse  : 1-clk pulse on debounced 1->0
//   long_pulse     : 1-clk pulse when the hold time reaches LONG_TICKS
//   repeat_pulse   : 1-clk pulse every REPEAT_TICKS ticks after long_pulse
module btn_input_conditioner_channel
    import btn_input_conditioner_pkg::*;
#(
    parameter int unsigned STABLE_N     = 8,
    parameter int unsigned LONG_TICKS   = 100000,
    parameter int unsigned REPEAT_TICKS = 20000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RepLast  =
        (REPEAT_TICKS > 0) ? CNT_W'(REPEAT_TICKS - 1) : '0;

    logic [1:0]          sync_q;
    logic [STABLE_N-1:0] shreg_q;
    logic [STABLE_N-1:0] shreg_next;
    logic                level_q;
    logic                level_dly_q;
    logic                level_next;
    btn_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                long_q;
    logic                repeat_q;

    // Level only moves on a full run of equal samples; partial patterns hold it.
    always_comb begin
        shreg_next = {shreg_q[STABLE_N-2:0], sync_q[1]};
        level_next = level_q;
        if (&shreg_next) begin
            level_next = 1'b1;
        end else if (~|shreg_next) begin
            level_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            shreg_q     <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn};
            level_dly_q <= level_q;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            if (tick) begin
                shreg_q <= shreg_next;
                level_q <= level_next;
                // The FSM looks at the level being written on this tick, so a release
                // on the tick that would also hit a threshold suppresses the pulse.
                if (!level_next) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end
                        StHeld: begin
                            if (cnt_q == LongLast) begin
                                long_q  <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= StLong;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        StLong: begin
                            if (REPEAT_TICKS == 0) begin
                                cnt_q <= '0;
                            end else if (cnt_q == RepLast) begin
                                repeat_q <= 1'b1;
                                cnt_q    <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign level         = level_q;
    assign press_pulse   = level_q & ~level_dly_q;
    assign release_pulse = ~level_q & level_dly_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/btn_input_conditioner.sv
// N-channel push-button conditioner for the front panel. Holds the shared sample-tick
// divider and one conditioning channel per button.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_btn      : raw asynchronous button inputs, active-high
//   o_level    : debounced levels
//   o_press    : 1-clk pulse on debounced 0->1
//   o_release  : 1-clk pulse on debounced 1->0
//   o_long     : 1-clk pulse when the hold time reaches LONG_TICKS
//   o_repeat   : 1-clk pulse every REPEAT_TICKS ticks after o_long while held
module btn_input_conditioner
    import btn_input_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned STABLE_N     = 8,
    parameter int unsigned LONG_TICKS   = 100000,
    parameter int unsigned REPEAT_TICKS = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat
);

    localparam int unsigned     DivW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
    localparam int unsigned     CntW    = cnt_width(LONG_TICKS, REPEAT_TICKS);

    logic [DivW-1:0] div_q;
    logic            tick;

    assign tick = (div_q == DivLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : gen_ch
        btn_input_conditioner_channel #(
            .STABLE_N     (STABLE_N),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .CNT_W        (CntW)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .btn           (i_btn[g]),
            .level         (o_level[g]),
            .press_pulse   (o_press[g]),
            .release_pulse (o_release[g]),
            .long_pulse    (o_long[g]),
            .repeat_pulse  (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_input_conditioner.sv
module tb_btn_input_conditioner;

    localparam int NB = 2;
    localparam int TD = 4;
    localparam int SN = 4;
    localparam int LT = 10;
    localparam int RT = 3;

    logic clk = 1'b0;
    logic rst;
    logic [NB-1:0] btn_a, btn_b;
    logic [NB-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
    logic [NB-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

    always #5 clk = ~clk;

    btn_input_conditioner #(
        .N_BTN(NB), .TICK_DIV(TD), .STABLE_N(SN), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) u_dut_a (
        .clk(clk), .rst(rst), .i_btn(btn_a), .o_level(lvl_a), .o_press(prs_a),
        .o_release(rel_a), .o_long(lng_a), .o_repeat(rep_a)
    );

    btn_input_conditioner #(
        .N_BTN(NB), .TICK_DIV(TD), .STABLE_N(SN), .LONG_TICKS(LT), .REPEAT_TICKS(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .i_btn(btn_b), .o_level(lvl_b), .o_press(prs_b),
        .o_release(rel_b), .o_long(lng_b), .o_repeat(rep_b)
    );

    wire [9:0]  got_a   = {lvl_a, prs_a, rel_a, lng_a, rep_a};
    wire [9:0]  got_b   = {lvl_b, prs_b, rel_b, lng_b, rep_b};
    wire [19:0] got_all = {got_a, got_b};

    // Reference model: the filter is a run-length of equal samples, hold time is ticks
    // elapsed since the debounced press.
    typedef struct {
        bit s1;
        bit s2;
        bit run_val;
        int run_len;
        bit level;
        bit level_prev;
        int held;
        bit long_p;
        bit rep_p;
    } chm_t;

    chm_t ma[NB];
    chm_t mb[NB];
    int   div;
    logic [19:0] exp_all;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int press_cnt[NB], rel_cnt[NB], long_cnt[NB], rep_cnt[NB];
    int press_cyc[NB], rel_cyc[NB], long_cyc[NB];
    int long_cnt_b, rep_cnt_b, model_rep_cnt;
    bit both_seen;
    int rep_q[$];

    function automatic chm_t ch_reset();
        chm_t r;
        r.s1 = 0; r.s2 = 0; r.run_val = 0; r.run_len = SN;
        r.level = 0; r.level_prev = 0; r.held = -1; r.long_p = 0; r.rep_p = 0;
        return r;
    endfunction

    function automatic chm_t ch_next(chm_t m, bit tick, bit b, int rep);
        chm_t n;
        bit synced;
        n = m;
        synced = m.s2;
        n.s2 = m.s1;
        n.s1 = b;
        n.level_prev = m.level;
        n.long_p = 0;
        n.rep_p = 0;
        if (tick) begin
            if (synced == m.run_val) begin
                n.run_len = (m.run_len < 1000) ? m.run_len + 1 : m.run_len;
            end else begin
                n.run_val = synced;
                n.run_len = 1;
            end
            if (n.run_len >= SN) n.level = n.run_val;
            if (!n.level) begin
                n.held = -1;
            end else if (m.held < 0) begin
                n.held = 0;
            end else begin
                n.held = m.held + 1;
                if (n.held == LT) n.long_p = 1;
                else if (n.held > LT && rep > 0 && ((n.held - LT) % rep) == 0) n.rep_p = 1;
            end
        end
        return n;
    endfunction

    function automatic logic [9:0] pack_exp(chm_t m0, chm_t m1);
        return {m1.level, m0.level,
                m1.level & ~m1.level_prev, m0.level & ~m0.level_prev,
                ~m1.level & m1.level_prev, ~m0.level & m0.level_prev,
                m1.long_p, m0.long_p, m1.rep_p, m0.rep_p};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NB; c++) begin
            ma[c] = ch_reset();
            mb[c] = ch_reset();
        end
        div = 0;
        exp_all = {pack_exp(ma[0], ma[1]), pack_exp(mb[0], mb[1])};
    endtask

    task automatic clr_obs();
        for (int c = 0; c < NB; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0; rep_cnt[c] = 0;
            press_cyc[c] = -1; rel_cyc[c] = -1; long_cyc[c] = -1;
        end
        long_cnt_b = 0; rep_cnt_b = 0; model_rep_cnt = 0; both_seen = 0;
        rep_q.delete();
    endtask

    // Advance one clock: model sees the same pre-edge inputs as the DUT, outputs are
    // observed 1 time unit after the edge.
    task automatic step();
        bit tick;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            tick = (div == TD - 1);
            for (int c = 0; c < NB; c++) begin
                ma[c] = ch_next(ma[c], tick, btn_a[c], RT);
                mb[c] = ch_next(mb[c], tick, btn_b[c], 0);
            end
            div = tick ? 0 : div + 1;
            exp_all = {pack_exp(ma[0], ma[1]), pack_exp(mb[0], mb[1])};
        end
        #1;
        cyc++;
        if (ma[0].rep_p) model_rep_cnt++;
        if (prs_a === 2'b11) both_seen = 1;
        for (int c = 0; c < NB; c++) begin
            if (prs_a[c] === 1'b1) begin press_cnt[c]++; press_cyc[c] = cyc; end
            if (rel_a[c] === 1'b1) begin rel_cnt[c]++; rel_cyc[c] = cyc; end
            if (lng_a[c] === 1'b1) begin long_cnt[c]++; long_cyc[c] = cyc; end
            if (rep_a[c] === 1'b1) begin
                rep_cnt[c]++;
                if (c == 0) rep_q.push_back(cyc);
            end
        end
        if (lng_b[0] === 1'b1) long_cnt_b++;
        if (rep_b[0] === 1'b1) rep_cnt_b++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_a = '0;
        btn_b = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (got_all !== 20'd0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0", cyc, got_all);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
    endtask

    task automatic test_clean_press();
        int start;
        clr_obs();
        for (int i = 0; i < int'($urandom_range(7, 0)); i++) step();
        btn_a[0] = 1'b1;
        start = cyc;
        for (int i = 0; i < 45 * TD; i++) begin
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL press_model cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
        total++;
        if (press_cnt[0] !== 1) begin
            bad++;
            $display("FAIL press_count got=%0d want=1", press_cnt[0]);
        end
        total++;
        if (press_cyc[0] - start < 2 + (SN - 1) * TD || press_cyc[0] - start > 2 + (SN + 1) * TD)
        begin
            bad++;
            $display("FAIL press_latency got=%0d want=%0d..%0d", press_cyc[0] - start,
                     2 + (SN - 1) * TD, 2 + (SN + 1) * TD);
        end
        total++;
        if (long_cyc[0] - press_cyc[0] !== LT * TD) begin
            bad++;
            $display("FAIL long_delay got=%0d want=%0d", long_cyc[0] - press_cyc[0], LT * TD);
        end
        total++;
        if (rep_q.size() < 2 || rep_q[0] - long_cyc[0] !== RT * TD) begin
            bad++;
            $display("FAIL first_repeat reps=%0d want gap=%0d", rep_q.size(), RT * TD);
        end
        for (int i = 1; i < rep_q.size(); i++) begin
            total++;
            if (rep_q[i] - rep_q[i-1] !== RT * TD) begin
                bad++;
                $display("FAIL repeat_gap got=%0d want=%0d", rep_q[i] - rep_q[i-1], RT * TD);
            end
        end
        total++;
        if (rep_cnt[0] !== model_rep_cnt || lvl_a[0] !== 1'b1) begin
            bad++;
            $display("FAIL repeat_count got=%0d want=%0d level=%b", rep_cnt[0], model_rep_cnt,
                     lvl_a[0]);
        end
        btn_a[0] = 1'b0;
        for (int i = 0; i < 8 * TD; i++) begin
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL press_drop cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
    endtask

    task automatic test_bounce();
        int half;
        clr_obs();
        half = $urandom_range(2 * TD, TD);
        for (int i = 0; i < int'($urandom_range(3, 0)); i++) step();
        for (int i = 0; i < 20 * TD + 15 * TD; i++) begin
            if (i < 20 * TD) btn_a[0] = ((i / half) % 2) == 0;
            else btn_a[0] = 1'b0;
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL bounce_model cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
        total++;
        if (press_cnt[0] !== 0 || rel_cnt[0] !== 0 || lvl_a[0] !== 1'b0) begin
            bad++;
            $display("FAIL bounce_quiet press=%0d release=%0d level=%b want 0 0 0",
                     press_cnt[0], rel_cnt[0], lvl_a[0]);
        end
    endtask

    task automatic test_short_release();
        int hold_ticks;
        int rel_start;
        bit seen;
        clr_obs();
        seen = 0;
        hold_ticks = $urandom_range(6, 4);
        btn_a[0] = 1'b1;
        for (int i = 0; i < 10 * TD; i++) begin
            step();
            if (prs_a[0] === 1'b1) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL short_press_timeout got=no press want=press");
        end
        for (int i = 0; i < hold_ticks * TD; i++) step();
        btn_a[0] = 1'b0;
        rel_start = cyc;
        for (int i = 0; i < 10 * TD; i++) begin
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL short_model cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
        total++;
        if (long_cnt[0] !== 0 || rel_cnt[0] !== 1) begin
            bad++;
            $display("FAIL short_release long=%0d release=%0d want 0 1", long_cnt[0], rel_cnt[0]);
        end
        total++;
        if (rel_cyc[0] - rel_start < 2 + (SN - 1) * TD || rel_cyc[0] - rel_start > 2 + (SN + 1) * TD)
        begin
            bad++;
            $display("FAIL release_latency got=%0d", rel_cyc[0] - rel_start);
        end
    endtask

    task automatic test_both_channels();
        int early;
        clr_obs();
        early = $urandom_range(6 * TD, 2 * TD);
        btn_a = 2'b11;
        for (int i = 0; i < 30 * TD; i++) begin
            if (press_cyc[1] >= 0 && cyc - press_cyc[1] == early) btn_a[1] = 1'b0;
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL both_model cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
        total++;
        if (!both_seen || press_cnt[1] !== 1 || rel_cnt[1] !== 1 || long_cnt[1] !== 0) begin
            bad++;
            $display("FAIL both_press seen=%0d p1=%0d r1=%0d l1=%0d want 1 1 1 0", both_seen,
                     press_cnt[1], rel_cnt[1], long_cnt[1]);
        end
        total++;
        if (long_cyc[0] - press_cyc[0] !== LT * TD || rep_q.size() < 1 ||
            rep_q[0] - long_cyc[0] !== RT * TD) begin
            bad++;
            $display("FAIL ch0_unaffected long_delay=%0d reps=%0d", long_cyc[0] - press_cyc[0],
                     rep_q.size());
        end
        btn_a = 2'b00;
        for (int i = 0; i < 8 * TD; i++) step();
    endtask

    task automatic test_reset_mid_long();
        int start;
        bit seen;
        clr_obs();
        seen = 0;
        btn_a[0] = 1'b1;
        for (int i = 0; i < 20 * TD; i++) begin
            step();
            if (lng_a[0] === 1'b1) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL long_timeout got=no long want=long");
        end
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (got_all !== 20'd0) begin
            bad++;
            $display("FAIL async_reset got=%b want=0", got_all);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (got_all !== 20'd0) begin
                bad++;
                $display("FAIL held_reset cyc=%0d got=%b want=0", cyc, got_all);
            end
        end
        rst = 1'b0;
        clr_obs();
        start = cyc;
        for (int i = 0; i < 18 * TD; i++) begin
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL post_reset_model cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
        total++;
        if (press_cnt[0] !== 1 || press_cyc[0] - start > 2 + (SN + 1) * TD ||
            long_cyc[0] - press_cyc[0] !== LT * TD) begin
            bad++;
            $display("FAIL repress press=%0d lat=%0d long_delay=%0d", press_cnt[0],
                     press_cyc[0] - start, long_cyc[0] - press_cyc[0]);
        end
        btn_a[0] = 1'b0;
        for (int i = 0; i < 8 * TD; i++) step();
    endtask

    task automatic test_no_repeat();
        clr_obs();
        btn_b[0] = 1'b1;
        for (int i = 0; i < 50 * TD; i++) begin
            step();
            total++;
            if (got_all !== exp_all) begin
                bad++;
                $display("FAIL norep_model cyc=%0d got=%b want=%b", cyc, got_all, exp_all);
            end
        end
        total++;
        if (long_cnt_b !== 1 || rep_cnt_b !== 0 || lvl_b[0] !== 1'b1) begin
            bad++;
            $display("FAIL no_repeat long=%0d repeat=%0d level=%b want 1 0 1", long_cnt_b,
                     rep_cnt_b, lvl_b[0]);
        end
        btn_b[0] = 1'b0;
        for (int i = 0; i < 8 * TD; i++) step();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_release();
        test_both_channels();
        test_reset_mid_long();
        test_no_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
